// File: rtl/reloj_pkg.sv
// Shared constants and types for the reloj display stage:
// 7-segment patterns, field limits, default dividers and the frame snapshot.
package reloj_pkg;

    localparam int SCAN_DIV_DEFAULT  = 4;
    localparam int BLINK_DIV_DEFAULT = 50;

    localparam logic [5:0] HORAS_MAX  = 6'd23;
    localparam logic [5:0] MINSEG_MAX = 6'd59;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef struct packed {
        logic [5:0] horas;
        logic [5:0] minutos;
        logic [5:0] segundos;
        logic       show_sec;
    } snap_t;

    function automatic logic [6:0] digit_to_seg(input logic [5:0] d);
        case (d)
            6'd0:    return SEG_0;
            6'd1:    return SEG_1;
            6'd2:    return SEG_2;
            6'd3:    return SEG_3;
            6'd4:    return SEG_4;
            6'd5:    return SEG_5;
            6'd6:    return SEG_6;
            6'd7:    return SEG_7;
            6'd8:    return SEG_8;
            6'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/reloj_bin2seg.sv
// Combinational binary-to-two-digit 7-segment converter for one time field.
// A value above its limit shows dashes on both digits.
module reloj_bin2seg
    import reloj_pkg::*;
(
    input  logic [5:0] value,
    input  logic [5:0] limit,
    output logic [6:0] tens,
    output logic [6:0] units
);

    logic [5:0] tens_val;
    logic [5:0] units_val;

    always_comb begin
        tens_val  = value / 6'd10;
        units_val = value % 6'd10;
        if (value > limit) begin
            tens  = SEG_DASH;
            units = SEG_DASH;
        end else begin
            tens  = digit_to_seg(tens_val);
            units = digit_to_seg(units_val);
        end
    end

endmodule

// File: rtl/reloj_display.sv
// Four-digit multiplexed 7-segment driver for the clock core: frame snapshot,
// digit scan, alarm blink/buzzer and registered outputs.
module reloj_display
    import reloj_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] HORAS,
    input  logic [5:0] MINUTOS,
    input  logic [5:0] SEGUNDOS,
    input  logic       ALARM,
    input  logic       SHOW_SEC,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       DP,
    output logic       BUZZER
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [DWELL_W-1:0] dwell;
    logic [1:0]         digit_idx;
    snap_t              snap;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    logic dwell_wrap;
    logic frame_end;

    assign dwell_wrap = (dwell == DWELL_LAST);
    assign frame_end  = dwell_wrap && (digit_idx == 2'd3);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dwell     <= '0;
            digit_idx <= 2'd0;
        end else if (dwell_wrap) begin
            dwell     <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            dwell     <= dwell + 1'b1;
        end
    end

    // Inputs are captured only at frame end so a frame never mixes two times
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            snap <= '0;
        end else if (frame_end) begin
            snap <= '{horas: HORAS, minutos: MINUTOS, segundos: SEGUNDOS, show_sec: SHOW_SEC};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (!ALARM) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    logic [6:0] hr_tens, hr_units, mn_tens, mn_units, sc_tens, sc_units;

    reloj_bin2seg u_horas (
        .value (snap.horas),
        .limit (HORAS_MAX),
        .tens  (hr_tens),
        .units (hr_units)
    );

    reloj_bin2seg u_minutos (
        .value (snap.minutos),
        .limit (MINSEG_MAX),
        .tens  (mn_tens),
        .units (mn_units)
    );

    reloj_bin2seg u_segundos (
        .value (snap.segundos),
        .limit (MINSEG_MAX),
        .tens  (sc_tens),
        .units (sc_units)
    );

    logic [6:0] seg_next;
    logic [3:0] an_next;
    logic       dp_next;
    logic       buzzer_next;
    logic       blank;

    always_comb begin
        seg_next = '0;
        case (digit_idx)
            2'd0: seg_next = snap.show_sec ? sc_units : mn_units;
            2'd1: seg_next = snap.show_sec ? sc_tens  : mn_tens;
            2'd2: seg_next = snap.show_sec ? mn_units : hr_units;
            2'd3: seg_next = snap.show_sec ? mn_tens  : hr_tens;
            default: seg_next = '0;
        endcase
        // Blanking gates only the enables; the scan keeps running underneath
        blank       = ALARM && !phase;
        an_next     = blank ? 4'b0000 : (4'b0001 << digit_idx);
        dp_next     = !blank && (digit_idx == 2'd2) && (snap.show_sec || !snap.segundos[0]);
        buzzer_next = ALARM && phase;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG    <= '0;
            AN     <= '0;
            DP     <= 1'b0;
            BUZZER <= 1'b0;
        end else begin
            SEG    <= seg_next;
            AN     <= an_next;
            DP     <= dp_next;
            BUZZER <= buzzer_next;
        end
    end

endmodule

// File: tb/tb_reloj_display.sv
// Scoreboard bench for reloj_display: a cycle-count reference model pushes the
// expected output of every clock edge and a negedge monitor compares it.
module tb_reloj_display;

    localparam int SD = 2;
    localparam int BD = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [5:0] HORAS, MINUTOS, SEGUNDOS;
    logic       ALARM, SHOW_SEC;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       DP, BUZZER;

    always #5 CLK = ~CLK;

    reloj_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .HORAS    (HORAS),
        .MINUTOS  (MINUTOS),
        .SEGUNDOS (SEGUNDOS),
        .ALARM    (ALARM),
        .SHOW_SEC (SHOW_SEC),
        .SEG      (SEG),
        .AN       (AN),
        .DP       (DP),
        .BUZZER   (BUZZER)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic       buzz;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Model state: cycles since reset release, cycles ALARM has been high, frame snapshot
    int t     = 0;
    int a_cnt = 0;
    int s_h   = 0;
    int s_m   = 0;
    int s_s   = 0;
    bit s_show = 1'b0;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] field_digit(input int v, input int lim, input bit tens);
        if (v > lim) return 7'h40;
        return pat(tens ? v / 10 : v % 10);
    endfunction

    task automatic check_output(input string name, input out_t act, input out_t exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s at %0t: got seg=%h an=%b dp=%b buzz=%b, expected seg=%h an=%b dp=%b buzz=%b",
                     name, $time, act.seg, act.an, act.dp, act.buzz, exp.seg, exp.an, exp.dp, exp.buzz);
        end
    endtask

    // Called just after a posedge: inputs still hold the values that edge sampled
    task automatic model_step();
        int   idx;
        bit   phase_on, blank;
        int   lv, llim, rv;
        out_t e;
        idx      = (t / SD) % 4;
        phase_on = ((a_cnt / BD) % 2) == 0;
        blank    = ALARM && !phase_on;
        lv   = s_show ? s_m : s_h;
        llim = s_show ? 59 : 23;
        rv   = s_show ? s_s : s_m;
        case (idx)
            0: e.seg = field_digit(rv, 59, 1'b0);
            1: e.seg = field_digit(rv, 59, 1'b1);
            2: e.seg = field_digit(lv, llim, 1'b0);
            default: e.seg = field_digit(lv, llim, 1'b1);
        endcase
        e.an   = blank ? 4'b0000 : 4'(1 << idx);
        e.dp   = !blank && idx == 2 && (s_show || (s_s % 2 == 0));
        e.buzz = ALARM && phase_on;
        exp_q.push_back(e);
        if (t % (4 * SD) == 4 * SD - 1) begin
            s_h    = int'(HORAS);
            s_m    = int'(MINUTOS);
            s_s    = int'(SEGUNDOS);
            s_show = SHOW_SEC;
        end
        a_cnt = ALARM ? a_cnt + 1 : 0;
        t++;
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            model_step();
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1 check_output("reset_async", {SEG, AN, DP, BUZZER}, '0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RESET = 1'b0;
        t = 0; a_cnt = 0; s_h = 0; s_m = 0; s_s = 0; s_show = 1'b0;
    endtask

    out_t mon_exp;
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_output("scan", {SEG, AN, DP, BUZZER}, mon_exp);
            end
        end
    end

    initial begin
        RESET = 1'b1;
        HORAS = '0; MINUTOS = '0; SEGUNDOS = '0; ALARM = 1'b0; SHOW_SEC = 1'b0;
        #2 check_output("reset_init", {SEG, AN, DP, BUZZER}, '0);
        @(negedge CLK);
        #1 RESET = 1'b0;

        apply_stimulus(8);
        HORAS = 6'd13; MINUTOS = 6'd45; SEGUNDOS = 6'd0;
        apply_stimulus(20);
        SEGUNDOS = 6'd7;
        apply_stimulus(16);
        SHOW_SEC = 1'b1; MINUTOS = 6'd7; SEGUNDOS = 6'd59;
        apply_stimulus(20);
        SHOW_SEC = 1'b0; MINUTOS = 6'd62;
        apply_stimulus(20);
        ALARM = 1'b1;
        apply_stimulus(40);
        ALARM = 1'b0;
        apply_stimulus(10);
        HORAS = 6'd13; MINUTOS = 6'd45;
        apply_stimulus(13);
        do_reset();
        apply_stimulus(24);

        repeat (150) begin
            HORAS    = 6'($urandom_range(0, 31));
            MINUTOS  = 6'($urandom_range(0, 63));
            SEGUNDOS = 6'($urandom_range(0, 63));
            SHOW_SEC = 1'($urandom_range(0, 1));
            ALARM    = ($urandom_range(0, 2) == 0);
            apply_stimulus($urandom_range(1, 25));
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reloj_display.md
# reloj_display

Downstream display stage for the digital clock counter. Takes the binary hours/minutes/seconds and alarm flag from the clock core and drives a 4-digit, time-multiplexed 7-segment display. It converts binary to decimal digits, scans the digits, and blinks the display and drives a buzzer while the alarm is active. It snapshots its inputs once per scan frame so a digit never shows a torn value.

## Interface
- SCAN_DIV, 4: clock cycles each digit stays lit (≥1)
- BLINK_DIV, 50: clock cycles per blink half-period while alarm active (≥1)
- CLK  in  1  clock; all state on posedge
- RESET  in  1  reset, asynchronous, active-high
- HORAS  in  6  binary hours, legal 0..23
- MINUTOS  in  6  binary minutes, legal 0..59
- SEGUNDOS  in  6  binary seconds, legal 0..59
- ALARM  in  1  alarm active level from clock core
- SHOW_SEC  in  1  0 = show HH:MM, 1 = show MM:SS
- SEG  out  7  segment pattern {g,f,e,d,c,b,a}, active-high
- AN  out  4  one-hot digit enable, active-high; bit 0 = rightmost digit
- DP  out  1  decimal point/separator, active-high
- BUZZER  out  1  buzzer drive, active-high

## Operation
- Reset: all registers clear immediately. SEG=0, AN=0000, DP=0, BUZZER=0. Digit index=0, dwell=0, snapshot=all zero, blink counter=0, phase=1.
- Dwell counter runs 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→2→3→0.
- Snapshot: HORAS, MINUTOS, SEGUNDOS and SHOW_SEC load at frame end (index=3 and dwell=SCAN_DIV-1). They are held for the whole next frame.
- Digit map:
  - SHOW_SEC=0: digit3/2 = hours tens/units; digit1/0 = minutes tens/units.
  - SHOW_SEC=1: digit3/2 = minutes tens/units; digit1/0 = seconds tens/units.
- Conversion: tens = v/10, units = v%10. Patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
- Out-of-range field (hours >23, minutes/seconds >59): both digits of that field show dash 40.
- DP is lit only while digit2 is driven:
  - SHOW_SEC=1: always lit.
  - SHOW_SEC=0: lit when snapshot SEGUNDOS is even (colon blink at 1 Hz of clock-core seconds).
- Blink:
  - ALARM=1: the blink counter counts 0..BLINK_DIV-1 and toggles phase at wrap. While phase=0, AN=0000 and DP=0; SEG still updates. BUZZER=phase.
  - ALARM=0: counter is held at 0, phase=1, BUZZER=0.
  - ALARM rising edge: counter starts from 0 with phase=1.
- Scanning never stops; blanking only gates AN and DP.

## Timing
- All outputs are registered. They reflect index/dwell/snapshot/phase from the previous cycle (1-cycle latency).
- First posedge after reset release: AN=0001, SEG=3F.
- Frame length: 4·SCAN_DIV cycles.
- Input-to-display latency: an input change appears at most 1 frame + 4·SCAN_DIV + 1 cycles later. Input changes mid-frame are never shown until the next snapshot.
- ALARM falling edge: BUZZER=0 and AN resumes scanning one cycle later.
- Reset mid-frame: outputs go to 0 asynchronously. The scan restarts at digit 0 and the next frame shows 00:00 until the first snapshot.

## Structure
- Shared package reloj_pkg holds:
  - 7-segment pattern constants for 0–9 and dash
  - field limits (23, 59)
  - SCAN_DIV/BLINK_DIV defaults
- One combinational sub-module, reloj_bin2seg: 6-bit value plus limit in, tens/units 7-bit patterns out (dash when over the limit). It is instantiated once per displayed field.
- Top level holds the dwell/index counters, snapshot register, blink counter/phase and output registers.

## Test plan
All scenarios use SCAN_DIV=2, BLINK_DIV=4.
- Reset, all inputs 0 → AN cycles 0001,0010,0100,1000, each for 2 cycles; SEG=3F throughout; BUZZER=0.
- HORAS=13, MINUTOS=45, SHOW_SEC=0, after one full frame → SEG: digit0=6D, digit1=66, digit2=4F, digit3=06. DP on digit2 follows SEGUNDOS parity.
- SHOW_SEC=1, MINUTOS=7, SEGUNDOS=59 → digit0=6F, digit1=6D, digit2=07, digit3=3F; DP=1 on digit2 only.
- MINUTOS=62, SHOW_SEC=0 → digits 0 and 1 show 40; hour digits are unaffected.
- ALARM=1 held → BUZZER 1 for 4 cycles, then 0 for 4 cycles, repeating; AN=0000 whenever BUZZER=0. ALARM=0 → BUZZER=0 and scanning resumes the next cycle.
- RESET pulsed mid-frame while showing 13:45 → all outputs 0 the same cycle. After release, AN=0001 and SEG=3F for the first frame, then 13:45 from the second frame.
